// File: rtl/addsub_multi_if.sv
// addsub_multi_if: operand/command and result bundle for addsub_multi
interface addsub_multi_if #(
  parameter int WIDTH = 32
);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic zero;
  logic overflow;
  modport master (
    output start, op, a, b, cin,
    input busy, done, sum, cout, zero, overflow
  );
  modport slave (
    input start, op, a, b, cin,
    output busy, done, sum, cout, zero, overflow
  );
endinterface

// File: rtl/addsub_multi.sv
// addsub_multi: multi-cycle sliced add/adc/sub/sbc, LSB slice first, with carry, zero and signed-overflow flags
module addsub_multi #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic reset,
  addsub_multi_if.slave bus
);
  localparam int N = WIDTH / SLICE;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [KW-1:0] k, k_d;
  logic [WIDTH-1:0] a_r, b_r, acc, a_d, b_d, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic carry, carry_d;
  logic done_q, done_d, cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [SLICE:0] slice_sum;
  logic last;
  always_comb begin
    last = k == KW'(N - 1);
    slice_sum = {1'b0, a_r[SLICE*int'(k) +: SLICE]} + {1'b0, b_r[SLICE*int'(k) +: SLICE]} + {{SLICE{1'b0}}, carry};
    state_d = state;
    k_d = k;
    a_d = a_r;
    b_d = b_r;
    acc_d = acc;
    carry_d = carry;
    done_d = 1'b0;
    sum_d = sum_q;
    cout_d = cout_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    if (state == IDLE) begin
      if (bus.start) begin
        a_d = bus.a;
        b_d = bus.op[1] ? ~bus.b : bus.b;
        carry_d = bus.op[0] ? bus.cin : bus.op[1];
        k_d = '0;
        state_d = RUN;
      end
    end else begin
      acc_d[SLICE*int'(k) +: SLICE] = slice_sum[SLICE-1:0];
      carry_d = slice_sum[SLICE];
      k_d = k + KW'(1);
      if (last) begin
        state_d = IDLE;
        done_d = 1'b1;
        sum_d = acc_d;
        cout_d = slice_sum[SLICE];
        zero_d = acc_d == '0;
        // carry into the MSB is recovered from the MSB sum bit and its operand bits
        ovf_d = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ acc_d[WIDTH-1] ^ slice_sum[SLICE];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      carry <= 1'b0;
      done_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_d;
      k <= k_d;
      a_r <= a_d;
      b_r <= b_d;
      acc <= acc_d;
      carry <= carry_d;
      done_q <= done_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = done_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_addsub_multi.sv
// tb_addsub_multi: random and directed checks of addsub_multi against an arithmetic reference model
module tb_addsub_multi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  addsub_multi_if #(.WIDTH(32)) w32 ();
  addsub_multi_if #(.WIDTH(8)) w8 ();
  addsub_multi #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .reset(reset), .bus(w32.slave));
  addsub_multi #(.WIDTH(8), .SLICE(8)) dut8 (.clk(clk), .reset(reset), .bus(w8.slave));
  typedef struct packed {
    logic ov;
    logic z;
    logic c;
    logic [31:0] s;
  } res_t;
  res_t last32;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // w-bit result computed with signed/unsigned integer arithmetic
  function automatic res_t model(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
    longint m, ua, ub, sa, sb, c, u, s;
    res_t r;
    m = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = ua >= m / 2 ? ua - m : ua;
    sb = ub >= m / 2 ? ub - m : ub;
    c = (op == 2'b01 && cin) || (op == 2'b11 && !cin) ? 1 : 0;
    if (op == 2'b10 || op == 2'b11) begin
      u = ua - ub - c;
      s = sa - sb - c;
      r.c = u >= 0;
    end else begin
      u = ua + ub + c;
      s = sa + sb + c;
      r.c = u >= m;
    end
    r.s = 32'(u & (m - 1));
    r.z = r.s == 0;
    r.ov = s >= m / 2 || s < -(m / 2);
    return r;
  endfunction
  task automatic op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input bit noisy, output int done_cyc);
    res_t e;
    int n, nb;
    e = model(32, op, a, b, cin);
    w32.start = 1'b1;
    w32.op = op;
    w32.a = a;
    w32.b = b;
    w32.cin = cin;
    @(negedge clk);
    n = 0;
    nb = 0;
    while (!w32.done && n < 20) begin
      nb += int'(w32.busy);
      check("hold", w32.sum, last32.s);
      w32.start = noisy ? 1'($urandom) : 1'b0;
      w32.op = 2'($urandom);
      w32.a = $urandom;
      w32.b = $urandom;
      w32.cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    w32.start = 1'b0;
    done_cyc = cyc;
    check("latency", n, 4);
    check("busy_cycles", nb, 4);
    check("busy_in_done", w32.busy, 0);
    check("sum", w32.sum, e.s);
    check("cout", w32.cout, e.c);
    check("zero", w32.zero, e.z);
    check("overflow", w32.overflow, e.ov);
    last32 = e;
  endtask
  task automatic op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    res_t e;
    e = model(8, op, {24'b0, a}, {24'b0, b}, cin);
    w8.start = 1'b1;
    w8.op = op;
    w8.a = a;
    w8.b = b;
    w8.cin = cin;
    @(negedge clk);
    w8.start = 1'b0;
    check("w8_busy", w8.busy, 1);
    check("w8_early_done", w8.done, 0);
    @(negedge clk);
    check("w8_done", w8.done, 1);
    check("w8_busy_in_done", w8.busy, 0);
    check("w8_sum", w8.sum, e.s);
    check("w8_cout", w8.cout, e.c);
    check("w8_zero", w8.zero, e.z);
    check("w8_overflow", w8.overflow, e.ov);
  endtask
  initial begin
    int d1, d2, n;
    logic [31:0] ra, rb;
    w32.start = 1'b0; w32.op = 2'b00; w32.a = '0; w32.b = '0; w32.cin = 1'b0;
    w8.start = 1'b0; w8.op = 2'b00; w8.a = '0; w8.b = '0; w8.cin = 1'b0;
    last32 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", w32.busy, 0);
    check("rst_done", w32.done, 0);
    check("rst_sum", w32.sum, 0);
    check("rst_cout", w32.cout, 0);
    check("rst_zero", w32.zero, 0);
    check("rst_overflow", w32.overflow, 0);
    check("rst_w8_busy", w8.busy, 0);
    check("rst_w8_sum", w8.sum, 0);
    op32(2'b00, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, d1);
    check("wrap_sum", w32.sum, 0);
    check("wrap_cout", w32.cout, 1);
    check("wrap_zero", w32.zero, 1);
    @(negedge clk);
    check("done_one_cycle", w32.done, 0);
    op32(2'b10, 32'd5, 32'd7, 1'b0, 1'b0, d1);
    check("sub_borrow_sum", w32.sum, 64'hFFFFFFFE);
    check("sub_borrow_cout", w32.cout, 0);
    op32(2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, d1);
    check("ovf_sum", w32.sum, 64'h80000000);
    check("ovf_flag", w32.overflow, 1);
    op32(2'b00, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, d1);
    op32(2'b01, 32'h1, 32'h0, last32.c, 1'b0, d1);
    check("chain_hi", w32.sum, 2);
    op32(2'b11, 32'h1, 32'h0, 1'b0, 1'b0, d1);
    check("sbc_borrow", w32.sum, 0);
    op32(2'b10, 32'h1, 32'h0, 1'b0, 1'b0, d1);
    check("plain_sub", w32.sum, 1);
    op32(2'b00, 32'd1000, 32'd234, 1'b0, 1'b1, d1);
    check("ignore_start", w32.sum, 1234);
    op32(2'b10, 32'd9, 32'd3, 1'b1, 1'b0, d2);
    check("back_to_back", d2 - d1, 5);
    w32.start = 1'b1; w32.op = 2'b00; w32.a = 32'd123; w32.b = 32'd456;
    @(negedge clk);
    w32.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", w32.busy, 0);
    check("abort_done", w32.done, 0);
    check("abort_sum", w32.sum, 0);
    check("abort_cout", w32.cout, 0);
    check("abort_overflow", w32.overflow, 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(w32.done);
    end
    check("abort_no_done", n, 0);
    last32 = '0;
    op32(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, d1);
    check("after_abort", w32.sum, 7);
    w32.start = 1'b1; w32.a = 32'd1; w32.b = 32'd1; w32.op = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    w32.start = 1'b0;
    check("reset_wins_busy", w32.busy, 0);
    check("reset_wins_sum", w32.sum, 0);
    last32 = '0;
    repeat (24) begin
      ra = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      rb = $urandom_range(0, 3) == 0 ? 32'h7FFFFFFF : $urandom;
      op32(2'($urandom), ra, rb, 1'($urandom), 1'($urandom), d1);
    end
    op8(2'b10, 8'h10, 8'h01, 1'b0);
    check("w8_sub_sum", w8.sum, 8'h0F);
    check("w8_sub_cout", w8.cout, 1);
    op8(2'b10, 8'h10, 8'h01, 1'b1);
    check("w8_cin_ignored", w8.sum, 8'h0F);
    repeat (10) op8(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/addsub_multi.md
# addsub_multi

Parametrised multi-cycle adder/subtractor for wide operands, processed LSB slice first with the carry chained through a register between slices. Supports add, add-with-carry, subtract and subtract-with-borrow, and returns carry, zero and signed-overflow flags. Sits beside the 8-bit ALU datapath as the arithmetic engine for multi-byte operations. Results are held stable between operations.

## Interface

Parameters:

- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH must be an exact multiple of SLICE; any other combination is unsupported. N = WIDTH/SLICE.

Ports:

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a new operation; sampled only when idle.
- op  in  2  00 add, 01 adc, 10 sub, 11 sbc.
- a  in  WIDTH  minuend / first addend.
- b  in  WIDTH  subtrahend / second addend.
- cin  in  1  carry input, used only by adc and sbc.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results updated.
- sum  out  WIDTH  result of last completed operation.
- cout  out  1  carry out of bit WIDTH-1. For sub/sbc, 1 means no borrow.
- zero  out  1  sum == 0.
- overflow  out  1  signed overflow of the WIDTH-bit result.

## Operation

- States: IDLE and RUN. The slice counter k runs 0..N-1.
- IDLE with start=1: latch a, b, op and cin into internal registers. Set k=0 and go to RUN.
- Initial carry c0 at latch time:
  - add = 0
  - adc = cin
  - sub = 1
  - sbc = cin
- For sub and sbc, b is inverted (~b) at latch time.
- RUN, each cycle: compute {c, s} = a[k] + b'[k] + carry over SLICE+1 bits.
  - Write s into the internal accumulator slice k.
  - Register c as the next carry.
  - Increment k.
- Last slice (k = N-1):
  - Copy the full accumulator to sum.
  - cout = final carry.
  - zero = (accumulator == 0).
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Assert done for the next cycle and go to IDLE.
- sum, cout, zero and overflow change only on the edge that raises done. Partial results are never visible.
- The flags come from the final WIDTH-bit result only. zero is not chained across separate operations.
- start while busy is ignored. It is not queued.
- Multi-word chaining is the caller's job: issue adc/sbc with cin = the previous cout.

## Timing

- Reset values:
  - state IDLE, k=0
  - busy=0, done=0
  - sum=0, cout=0, zero=0, overflow=0
- Start sampled on edge E0. busy=1 from after E0 through edge E0+N. done=1 for exactly the one cycle following edge E0+N, and busy=0 in that cycle.
- Latency: N cycles from start to done. Throughput: one operation per N+1 cycles when start is reasserted during the done cycle. start in the done cycle is accepted because the state is IDLE.
- Inputs a, b, op and cin matter only at the sampling edge. Changes during RUN have no effect.
- N=1 (SLICE=WIDTH): busy is high for one cycle, and done follows on the next cycle.
- reset during RUN:
  - abort the operation
  - all outputs return to their reset values on that edge
  - no done pulse
- reset and start in the same cycle: reset wins.

## Test plan

Defaults WIDTH=32, SLICE=8 unless stated.

- add a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1, zero=1, overflow=0. done exactly 4 cycles after the start edge; busy high for 4 cycles.
- sub a=5, b=7 -> sum=0xFFFFFFFE, cout=0 (borrow), zero=0, overflow=0. Then add a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, cout=0.
- 64-bit chain as two 32-bit ops: add 0x00000001_FFFFFFFF + 0x00000000_00000001, low word then adc with cin=previous cout -> high sum=0x00000002, low sum=0x00000000. Then sbc the high words with cin=0 -> borrow is propagated (high result one less than plain sub).
- Pulse start again at cycles 1-3 of a busy operation -> ignored; result matches the first operands only. Reassert start in the done cycle -> accepted, with the second done 5 cycles after the first.
- Assert reset in the 2nd RUN cycle -> next cycle shows busy=0, done=0 and all outputs 0, with no done pulse. A following add 3+4 -> sum=7.
- Instance WIDTH=8, SLICE=8: sub a=0x10, b=0x01 with cin=0 -> sum=0x0F, cout=1. cin is ignored for sub. done arrives the cycle after busy.
